// File: rtl/stage_if_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order word fetches to a
// variable-latency instruction memory, buffers the returned words with their
// link PC (fetch address + 4) and presents the buffer head to IF/ID.
// A taken branch redirects the PC, empties the buffer and marks every fetch
// still in flight as stale so that its response is thrown away on return.
module stage_if_fetch #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branchTaken,
   input  logic [31:0] branchAddr,
   output logic        imemReqValid,
   input  logic        imemReqReady,
   output logic [31:0] imemAddr,
   input  logic        imemRespValid,
   input  logic [31:0] imemRespData,
   output logic [31:0] pcOut,
   output logic [31:0] instOut,
   output logic        instValid
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int LW = CW + 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
   localparam logic [LW-1:0] LEVEL_MAX = LW'(DEPTH);
   localparam logic [AW-1:0] IDX_LAST  = AW'(DEPTH - 1);

   // Circular-buffer index increment that also works for non-power-of-2 depths.
   function automatic logic [AW-1:0] idx_next(input logic [AW-1:0] idx);
      logic [AW-1:0] nxt;
      if (idx == IDX_LAST) begin
         nxt = '0;
      end else begin
         nxt = idx + AW'(32'd1);
      end
      return nxt;
   endfunction

   // Architectural PC and request bookkeeping.
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;

   // Fetch buffer: link PC and instruction word per entry.
   logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [AW-1:0] fifo_rd_q, fifo_rd_d;
   logic [AW-1:0] fifo_wr_q, fifo_wr_d;
   logic [31:0]   fifo_pc_q   [DEPTH];
   logic [31:0]   fifo_pc_d   [DEPTH];
   logic [31:0]   fifo_inst_q [DEPTH];
   logic [31:0]   fifo_inst_d [DEPTH];

   // Address queue: fetch address of each request still in flight, oldest first.
   logic [AW-1:0] aq_rd_q, aq_rd_d;
   logic [AW-1:0] aq_wr_q, aq_wr_d;
   logic [31:0]   aq_addr_q [DEPTH];
   logic [31:0]   aq_addr_d [DEPTH];

   // Per-cycle handshake decisions.
   logic [LW-1:0] level_s;
   logic          req_valid_s;
   logic          accept_s;
   logic          inst_valid_s;
   logic          resp_drop_s;
   logic          push_s;
   logic          pop_s;
   logic          fifo_full_s;

   // Decide issue, response routing and consumption for this cycle.
   always_comb begin
      level_s      = {1'b0, fifo_cnt_q} + {1'b0, out_cnt_q};
      // Gating with rst keeps the request low while reset is held.
      req_valid_s  = rst & ~branchTaken & (level_s < LEVEL_MAX);
      accept_s     = req_valid_s & imemReqReady;
      inst_valid_s = (fifo_cnt_q != '0);
      // Stale responses: either flagged by an earlier branch or arriving with one.
      resp_drop_s  = imemRespValid & (branchTaken | (drop_cnt_q != '0));
      push_s       = imemRespValid & ~resp_drop_s;
      pop_s        = inst_valid_s & ~freeze & ~branchTaken;
      fifo_full_s  = (fifo_cnt_q == CNT_FULL);
   end

   // Next PC, outstanding-request count and stale-response count.
   always_comb begin
      pc_d       = pc_q;
      out_cnt_d  = out_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (branchTaken) begin
         pc_d = branchAddr;
         // Everything still outstanding after this cycle's response is stale.
         if (imemRespValid) begin
            drop_cnt_d = out_cnt_q - CNT_ONE;
         end else begin
            drop_cnt_d = out_cnt_q;
         end
      end else begin
         if (accept_s) begin
            pc_d = pc_q + 32'd4;
         end else begin
            pc_d = pc_q;
         end
         if (resp_drop_s) begin
            drop_cnt_d = drop_cnt_q - CNT_ONE;
         end else begin
            drop_cnt_d = drop_cnt_q;
         end
      end
      case ({accept_s, imemRespValid})
         2'b10:   out_cnt_d = out_cnt_q + CNT_ONE;
         2'b01:   out_cnt_d = out_cnt_q - CNT_ONE;
         default: out_cnt_d = out_cnt_q;
      endcase
   end

   // Fetch-buffer push/pop; a branch empties it.
   always_comb begin
      fifo_pc_d   = fifo_pc_q;
      fifo_inst_d = fifo_inst_q;
      fifo_rd_d   = fifo_rd_q;
      fifo_wr_d   = fifo_wr_q;
      fifo_cnt_d  = fifo_cnt_q;
      if (branchTaken) begin
         fifo_rd_d  = '0;
         fifo_wr_d  = '0;
         fifo_cnt_d = '0;
      end else begin
         if (push_s) begin
            fifo_pc_d[fifo_wr_q]   = aq_addr_q[aq_rd_q] + 32'd4;
            fifo_inst_d[fifo_wr_q] = imemRespData;
            fifo_wr_d              = idx_next(fifo_wr_q);
         end else begin
            fifo_wr_d = fifo_wr_q;
         end
         if (pop_s) begin
            fifo_rd_d = idx_next(fifo_rd_q);
         end else begin
            fifo_rd_d = fifo_rd_q;
         end
         case ({push_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
            default: fifo_cnt_d = fifo_cnt_q;
         endcase
      end
   end

   // Address queue: record each accepted address, retire one per response
   // (dropped responses retire their entry too, keeping it aligned).
   always_comb begin
      aq_addr_d = aq_addr_q;
      aq_wr_d   = aq_wr_q;
      aq_rd_d   = aq_rd_q;
      if (accept_s) begin
         aq_addr_d[aq_wr_q] = pc_q;
         aq_wr_d            = idx_next(aq_wr_q);
      end else begin
         aq_wr_d = aq_wr_q;
      end
      if (imemRespValid) begin
         aq_rd_d = idx_next(aq_rd_q);
      end else begin
         aq_rd_d = aq_rd_q;
      end
   end

   // Drive the memory request and the IF/ID view of the buffer head.
   always_comb begin
      imemReqValid = req_valid_s;
      imemAddr     = pc_q;
      instValid    = inst_valid_s;
      if (inst_valid_s) begin
         pcOut   = fifo_pc_q[fifo_rd_q];
         instOut = fifo_inst_q[fifo_rd_q];
      end else begin
         pcOut   = 32'h0000_0000;
         instOut = 32'h0000_0000;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q        <= RESET_PC;
         out_cnt_q   <= '0;
         drop_cnt_q  <= '0;
         fifo_cnt_q  <= '0;
         fifo_rd_q   <= '0;
         fifo_wr_q   <= '0;
         fifo_pc_q   <= '{default: 32'h0000_0000};
         fifo_inst_q <= '{default: 32'h0000_0000};
         aq_rd_q     <= '0;
         aq_wr_q     <= '0;
         aq_addr_q   <= '{default: 32'h0000_0000};
      end else begin
         pc_q        <= pc_d;
         out_cnt_q   <= out_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         fifo_cnt_q  <= fifo_cnt_d;
         fifo_rd_q   <= fifo_rd_d;
         fifo_wr_q   <= fifo_wr_d;
         fifo_pc_q   <= fifo_pc_d;
         fifo_inst_q <= fifo_inst_d;
         aq_rd_q     <= aq_rd_d;
         aq_wr_q     <= aq_wr_d;
         aq_addr_q   <= aq_addr_d;
      end
   end

   // The issue cap must make a push into a full buffer impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(push_s && fifo_full_s));

   // Stale responses can never outnumber the requests in flight.
   a_drop_bounded: assert property (@(posedge clk) disable iff (!rst)
      drop_cnt_q <= out_cnt_q);

endmodule
